// File: rtl/i2c_resp_pkg.sv
// Shared types and constants for the I2C register responder: FSM state encoding,
// default target address, bus ACK/NACK levels and a majority helper for the bus filter.
package i2c_resp_pkg;

   typedef enum logic [3:0] {
      IDLE,
      ADDR,
      ADDR_ACK,
      PTR,
      PTR_ACK,
      WDATA,
      WDATA_ACK,
      RDATA,
      RDATA_ACK
   } state_t;

   localparam logic [6:0] DEV_ADDR_DEFAULT = 7'h50;

   // Open-drain levels: ACK pulls the line low, NACK doubles as "released".
   localparam logic ACK_LVL  = 1'b0;
   localparam logic NACK_LVL = 1'b1;

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/i2c_bus_sync.sv
// Bus front end: 2-flop synchronisers on SCL/SDA, optional 2-of-3 majority filter
// (macro I2C_RESP_GLITCH_FILTER_EN), SCL edge and START/STOP detection.
module i2c_bus_sync
   import i2c_resp_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic scl_i,
   input  logic sda_i,
   output logic sda,
   output logic scl_rise,
   output logic scl_fall,
   output logic start,
   output logic stop
);

   logic [1:0] raw;
   logic [1:0] line;
   logic [1:0] prev_reg;

   assign raw = {scl_i, sda_i};

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_line
         logic meta_reg;
         logic sync_reg;

         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               meta_reg <= 1'b1;
               sync_reg <= 1'b1;
            end else begin
               meta_reg <= raw[gi];
               sync_reg <= meta_reg;
            end
         end

`ifdef I2C_RESP_GLITCH_FILTER_EN
         logic [1:0] hist_reg;
         logic       filt_reg;

         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               hist_reg <= 2'b11;
               filt_reg <= 1'b1;
            end else begin
               hist_reg <= {hist_reg[0], sync_reg};
               filt_reg <= maj3(sync_reg, hist_reg[0], hist_reg[1]);
            end
         end

         assign line[gi] = filt_reg;
`else
         assign line[gi] = sync_reg;
`endif
      end
   endgenerate

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         prev_reg <= 2'b11;
      end else begin
         prev_reg <= line;
      end
   end

   assign sda      = line[0];
   assign scl_rise = line[1] & ~prev_reg[1];
   assign scl_fall = ~line[1] & prev_reg[1];
   // SDA may only move with SCL high across both samples for a bus condition.
   assign start    = line[1] & prev_reg[1] & prev_reg[0] & ~line[0];
   assign stop     = line[1] & prev_reg[1] & ~prev_reg[0] & line[0];

endmodule

// File: rtl/i2c_responder.sv
// I2C target exposing a NUM_REGS x 8 register file with an auto-incrementing pointer.
// Build option: I2C_RESP_GLITCH_FILTER_EN enables the bus majority filter.
module i2c_responder
   import i2c_resp_pkg::*;
#(
   parameter logic [6:0] DEV_ADDR = DEV_ADDR_DEFAULT,
   parameter int         NUM_REGS = 16
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        scl_i,
   input  logic                        sda_i,
   output logic                        resp_sda_o,
   output logic                        busy,
   output logic                        wr_stb,
   output logic [$clog2(NUM_REGS)-1:0] wr_idx,
   output logic [7:0]                  wr_data
);

   localparam int IDX_W = $clog2(NUM_REGS);

   logic sda;
   logic scl_rise;
   logic scl_fall;
   logic start;
   logic stop;

   i2c_bus_sync u_bus_sync (
      .clk      (clk),
      .rst      (rst),
      .scl_i    (scl_i),
      .sda_i    (sda_i),
      .sda      (sda),
      .scl_rise (scl_rise),
      .scl_fall (scl_fall),
      .start    (start),
      .stop     (stop)
   );

   state_t           state_reg, state_next;
   logic [2:0]       bit_cnt_reg, bit_cnt_next;
   logic [6:0]       shift_reg, shift_next;
   logic [IDX_W-1:0] ptr_reg, ptr_next;
   logic             sda_reg, sda_next;
   logic             busy_reg, busy_next;
   logic             ack_phase_reg, ack_phase_next;
   logic             rw_reg, rw_next;
   logic             wr_stb_reg;
   logic [IDX_W-1:0] wr_idx_reg;
   logic [7:0]       wr_data_reg;
   logic             reg_we;
   logic [7:0]       byte_in;
   logic [7:0]       rd_byte;
   logic [7:0]       regs [NUM_REGS];

   // The byte completes on the 8th rising edge, so fold in the live SDA sample.
   assign byte_in = {shift_reg, sda};
   assign rd_byte = regs[ptr_reg];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg     <= IDLE;
         bit_cnt_reg   <= 3'd0;
         shift_reg     <= 7'd0;
         ptr_reg       <= '0;
         sda_reg       <= NACK_LVL;
         busy_reg      <= 1'b0;
         ack_phase_reg <= 1'b0;
         rw_reg        <= 1'b0;
         wr_stb_reg    <= 1'b0;
         wr_idx_reg    <= '0;
         wr_data_reg   <= 8'h00;
      end else begin
         state_reg     <= state_next;
         bit_cnt_reg   <= bit_cnt_next;
         shift_reg     <= shift_next;
         ptr_reg       <= ptr_next;
         sda_reg       <= sda_next;
         busy_reg      <= busy_next;
         ack_phase_reg <= ack_phase_next;
         rw_reg        <= rw_next;
         wr_stb_reg    <= reg_we;
         if (reg_we) begin
            wr_idx_reg  <= ptr_reg;
            wr_data_reg <= byte_in;
         end
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               regs[gi] <= 8'h00;
            end else if (reg_we && (ptr_reg == IDX_W'(gi))) begin
               regs[gi] <= byte_in;
            end
         end
      end
   endgenerate

   always_comb begin
      state_next     = state_reg;
      bit_cnt_next   = bit_cnt_reg;
      shift_next     = shift_reg;
      ptr_next       = ptr_reg;
      sda_next       = sda_reg;
      busy_next      = busy_reg;
      ack_phase_next = ack_phase_reg;
      rw_next        = rw_reg;
      reg_we         = 1'b0;

      if (stop) begin
         state_next     = IDLE;
         sda_next       = NACK_LVL;
         busy_next      = 1'b0;
         ack_phase_next = 1'b0;
      end else if (start) begin
         state_next     = ADDR;
         bit_cnt_next   = 3'd0;
         sda_next       = NACK_LVL;
         ack_phase_next = 1'b0;
      end else begin
         unique case (state_reg)
            IDLE: ;

            ADDR, PTR, WDATA: begin
               if (scl_rise) begin
                  shift_next   = byte_in[6:0];
                  bit_cnt_next = bit_cnt_reg + 3'd1;
                  if (bit_cnt_reg == 3'd7) begin
                     if (state_reg == ADDR) begin
                        if (byte_in[7:1] == DEV_ADDR) begin
                           state_next = ADDR_ACK;
                           rw_next    = byte_in[0];
                           busy_next  = 1'b1;
                        end else begin
                           state_next = IDLE;
                           busy_next  = 1'b0;
                        end
                     end else if (state_reg == PTR) begin
                        ptr_next   = byte_in[IDX_W-1:0];
                        state_next = PTR_ACK;
                     end else begin
                        reg_we     = 1'b1;
                        ptr_next   = ptr_reg + 1'b1;
                        state_next = WDATA_ACK;
                     end
                  end
               end
            end

            // First falling edge pulls SDA low, the second one ends the ACK slot.
            ADDR_ACK, PTR_ACK, WDATA_ACK: begin
               if (scl_fall) begin
                  if (!ack_phase_reg) begin
                     sda_next       = ACK_LVL;
                     ack_phase_next = 1'b1;
                  end else begin
                     ack_phase_next = 1'b0;
                     bit_cnt_next   = 3'd0;
                     sda_next       = NACK_LVL;
                     if (state_reg == ADDR_ACK) begin
                        if (rw_reg) begin
                           state_next = RDATA;
                           sda_next   = rd_byte[7];
                        end else begin
                           state_next = PTR;
                        end
                     end else begin
                        state_next = WDATA;
                     end
                  end
               end
            end

            RDATA: begin
               if (scl_rise) begin
                  bit_cnt_next = bit_cnt_reg + 3'd1;
                  if (bit_cnt_reg == 3'd7) begin
                     state_next = RDATA_ACK;
                  end
               end else if (scl_fall) begin
                  sda_next = rd_byte[3'd7 - bit_cnt_reg];
               end
            end

            RDATA_ACK: begin
               if (scl_fall) begin
                  sda_next = NACK_LVL;
               end else if (scl_rise) begin
                  if (sda == ACK_LVL) begin
                     ptr_next     = ptr_reg + 1'b1;
                     bit_cnt_next = 3'd0;
                     state_next   = RDATA;
                  end else begin
                     sda_next   = NACK_LVL;
                     state_next = IDLE;
                  end
               end
            end

            default: state_next = IDLE;
         endcase
      end
   end

   assign resp_sda_o = sda_reg;
   assign busy       = busy_reg;
   assign wr_stb     = wr_stb_reg;
   assign wr_idx     = wr_idx_reg;
   assign wr_data    = wr_data_reg;

endmodule

// File: tb/tb_i2c_responder.sv
// Directed bench for i2c_responder: a bit-banged bus master plus a transaction-level
// register/pointer model, checked per cycle during every SCL-high window.
module tb_i2c_responder;

   localparam int H      = 12;
   localparam int P_NONE = 0;
   localparam int P_ADDR = 1;
   localparam int P_PTR  = 2;
   localparam int P_DATA = 3;
   localparam int P_READ = 4;

   typedef struct packed {
      logic [3:0] idx;
      logic [7:0] data;
   } ev_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       scl_m = 1'b1;
   logic       sda_m = 1'b1;
   logic       resp_sda_o;
   logic       busy;
   logic       wr_stb;
   logic [3:0] wr_idx;
   logic [7:0] wr_data;
   wire        sda_bus = sda_m & resp_sda_o;

   int         checks = 0;
   int         failures = 0;
   logic [7:0] m_regs [16];
   int         m_ptr = 0;
   logic       m_busy = 1'b0;
   int         m_phase = P_NONE;
   logic       chk_en = 1'b0;
   logic       exp_sda = 1'b1;
   logic       prev_stb = 1'b0;
   ev_t        exp_q[$];
   ev_t        wr_log[$];
   ev_t        ev;

   always #5 clk = ~clk;

   i2c_responder dut (
      .clk        (clk),
      .rst        (rst),
      .scl_i      (scl_m),
      .sda_i      (sda_bus),
      .resp_sda_o (resp_sda_o),
      .busy       (busy),
      .wr_stb     (wr_stb),
      .wr_idx     (wr_idx),
      .wr_data    (wr_data)
   );

   always @(negedge clk) begin
      if (chk_en && rst) begin
         checks++;
         if (resp_sda_o !== exp_sda) begin
            failures++;
            $display("FAIL sda_slot t=%0t got=%b want=%b", $time, resp_sda_o, exp_sda);
         end
         checks++;
         if (busy !== m_busy) begin
            failures++;
            $display("FAIL busy_slot t=%0t got=%b want=%b", $time, busy, m_busy);
         end
      end
      if (wr_stb === 1'b1) begin
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL wr_unexpected t=%0t got idx=%0d data=%02h want no write", $time, wr_idx, wr_data);
         end else begin
            ev = exp_q.pop_front();
            if (wr_idx !== ev.idx || wr_data !== ev.data) begin
               failures++;
               $display("FAIL wr_event t=%0t got idx=%0d data=%02h want idx=%0d data=%02h",
                        $time, wr_idx, wr_data, ev.idx, ev.data);
            end
         end
         wr_log.push_back({wr_idx, wr_data});
         checks++;
         if (prev_stb) begin
            failures++;
            $display("FAIL wr_stb_width t=%0t got=2+ cycles want=1 cycle", $time);
         end
      end
      prev_stb = (wr_stb === 1'b1);
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s got=%0h want=%0h", name, got, want);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 16; i++) m_regs[i] = 8'h00;
      m_ptr   = 0;
      m_busy  = 1'b0;
      m_phase = P_NONE;
   endtask

   task automatic clock_bit(input logic drive, input logic expect_resp, output logic sampled);
      repeat (H/2) @(posedge clk);
      sda_m = drive;
      repeat (H/2) @(posedge clk);
      exp_sda = expect_resp;
      scl_m = 1'b1;
      repeat (7) @(posedge clk);
      chk_en = 1'b1;
      repeat (H-7) @(posedge clk);
      sampled = sda_bus;
      chk_en = 1'b0;
      scl_m = 1'b0;
   endtask

   task automatic bus_start();
      repeat (H/2) @(posedge clk);
      sda_m = 1'b1;
      repeat (H/2) @(posedge clk);
      scl_m = 1'b1;
      repeat (H) @(posedge clk);
      sda_m = 1'b0;
      repeat (H) @(posedge clk);
      scl_m = 1'b0;
      m_phase = P_ADDR;
   endtask

   task automatic bus_stop();
      repeat (H/2) @(posedge clk);
      sda_m = 1'b0;
      repeat (H/2) @(posedge clk);
      scl_m = 1'b1;
      repeat (H) @(posedge clk);
      chk("sda_released_at_stop", resp_sda_o, 1);
      sda_m = 1'b1;
      m_busy = 1'b0;
      m_phase = P_NONE;
      repeat (2*H) @(posedge clk);
      chk("busy_after_stop", busy, 0);
   endtask

   task automatic send_byte(input logic [7:0] b);
      logic s;
      logic ack_exp;
      for (int i = 7; i >= 1; i--) clock_bit(b[i], 1'b1, s);
      ack_exp = 1'b0;
      case (m_phase)
         P_ADDR: begin
            if (b[7:1] == 7'h50) begin
               ack_exp = 1'b1;
               m_busy  = 1'b1;
               m_phase = b[0] ? P_READ : P_PTR;
            end else begin
               m_busy  = 1'b0;
               m_phase = P_NONE;
            end
         end
         P_PTR: begin
            ack_exp = 1'b1;
            m_ptr   = b % 16;
            m_phase = P_DATA;
         end
         P_DATA: begin
            ack_exp = 1'b1;
            exp_q.push_back({4'(m_ptr), b});
            m_regs[m_ptr] = b;
            m_ptr = (m_ptr + 1) % 16;
         end
         default: ack_exp = 1'b0;
      endcase
      clock_bit(b[0], 1'b1, s);
      clock_bit(1'b1, ack_exp ? 1'b0 : 1'b1, s);
   endtask

   task automatic recv_byte(input logic master_ack, output logic [7:0] got);
      logic       s;
      logic [7:0] want;
      want = m_regs[m_ptr];
      for (int i = 7; i >= 0; i--) begin
         clock_bit(1'b1, want[i], s);
         got[i] = s;
      end
      clock_bit(master_ack ? 1'b0 : 1'b1, 1'b1, s);
      if (master_ack) m_ptr = (m_ptr + 1) % 16;
      else m_phase = P_NONE;
   endtask

   initial begin
      #10_000_000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [7:0] g0;
      logic [7:0] g1;
      model_reset();

      // Reset state
      #1 rst = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      chk("rst_sda", resp_sda_o, 1);
      chk("rst_busy", busy, 0);
      chk("rst_wr_stb", wr_stb, 0);
      chk("rst_wr_idx", wr_idx, 0);
      chk("rst_wr_data", wr_data, 0);
      @(negedge clk) rst = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      chk("idle_sda", resp_sda_o, 1);
      chk("idle_busy", busy, 0);

      // All registers read back zero from pointer 0
      bus_start();
      send_byte(8'hA1);
      for (int i = 0; i < 16; i++) begin
         recv_byte(i < 15, g0);
         chk($sformatf("reset_reg%0d", i), g0, 8'h00);
      end
      bus_stop();

      // Write 0x5A, 0xC3 from pointer 3
      wr_log.delete();
      bus_start();
      send_byte(8'hA0);
      send_byte(8'h03);
      send_byte(8'h5A);
      send_byte(8'hC3);
      bus_stop();
      chk("t2_wr_count", wr_log.size(), 2);
      if (wr_log.size() >= 2) begin
         chk("t2_wr0_idx", wr_log[0].idx, 4'd3);
         chk("t2_wr0_data", wr_log[0].data, 8'h5A);
         chk("t2_wr1_idx", wr_log[1].idx, 4'd4);
         chk("t2_wr1_data", wr_log[1].data, 8'hC3);
      end

      // Pointer set, repeated START, read two bytes
      bus_start();
      send_byte(8'hA0);
      send_byte(8'h03);
      bus_start();
      send_byte(8'hA1);
      recv_byte(1'b1, g0);
      recv_byte(1'b0, g1);
      bus_stop();
      chk("t3_rd0", g0, 8'h5A);
      chk("t3_rd1", g1, 8'hC3);

      // Wrong address is ignored
      wr_log.delete();
      bus_start();
      send_byte(8'hA2);
      send_byte(8'h77);
      bus_stop();
      chk("t4_no_write", wr_log.size(), 0);
      chk("t4_busy", busy, 0);

      // Pointer wrap 15 -> 0
      wr_log.delete();
      bus_start();
      send_byte(8'hA0);
      send_byte(8'h0F);
      send_byte(8'h11);
      send_byte(8'h22);
      bus_stop();
      chk("t5_wr_count", wr_log.size(), 2);
      if (wr_log.size() >= 2) begin
         chk("t5_wr0_idx", wr_log[0].idx, 4'd15);
         chk("t5_wr0_data", wr_log[0].data, 8'h11);
         chk("t5_wr1_idx", wr_log[1].idx, 4'd0);
         chk("t5_wr1_data", wr_log[1].data, 8'h22);
      end
      bus_start();
      send_byte(8'hA0);
      send_byte(8'h0F);
      bus_start();
      send_byte(8'hA1);
      recv_byte(1'b1, g0);
      recv_byte(1'b0, g1);
      bus_stop();
      chk("t5_rd15", g0, 8'h11);
      chk("t5_rd0", g1, 8'h22);

      // Reset while the responder drives a 0 read bit (reg0 = 0x22, MSB 0)
      bus_start();
      send_byte(8'hA1);
      repeat (H/2) @(posedge clk);
      chk("t6_bit_driven_low", resp_sda_o, 0);
      #2 rst = 1'b0;
      #1;
      chk("t6_sda_released", resp_sda_o, 1);
      chk("t6_busy", busy, 0);
      chk("t6_wr_idx", wr_idx, 0);
      chk("t6_wr_data", wr_data, 0);
      model_reset();
      repeat (3) @(posedge clk);
      #2 rst = 1'b1;
      send_byte(8'hA0);
      bus_stop();
      bus_start();
      send_byte(8'hA1);
      recv_byte(1'b0, g0);
      bus_stop();
      chk("t6_reg0_cleared", g0, 8'h00);

      chk("exp_queue_drained", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
